// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_burst_reader_if                                             |
// | Purpose : Bundles the burst-control, FIFO read-port and output-stream      |
// |           signals of fifo_burst_reader.                                    |
// | Ports   : start_i/len_i          burst request                             |
// |           fifo_pnding_i/data_i   FIFO head status and word                 |
// |           fifo_pop_o             pop request to the FIFO                   |
// |           m_valid_o/data_o/ready_i  valid/ready output stream              |
// |           busy_o/done_o/count_o  burst status                              |
// | Modports: master = reader engine, slave = FIFO/sink/controller side        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface fifo_burst_reader_if #(
  parameter int BITS  = 32,
  parameter int LEN_W = 8
);
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             fifo_pnding_i;
  logic [BITS-1:0]  fifo_data_i;
  logic             fifo_pop_o;
  logic             m_valid_o;
  logic [BITS-1:0]  m_data_o;
  logic             m_ready_i;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] count_o;

  modport master (
    input  start_i, len_i, fifo_pnding_i, fifo_data_i, m_ready_i,
    output fifo_pop_o, m_valid_o, m_data_o, busy_o, done_o, count_o
  );

  modport slave (
    output start_i, len_i, fifo_pnding_i, fifo_data_i, m_ready_i,
    input  fifo_pop_o, m_valid_o, m_data_o, busy_o, done_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_burst_reader                                                |
// | Purpose : Drains a requested number of words from a FIFO read port and     |
// |           delivers them on a valid/ready stream through a 2-entry output   |
// |           buffer, so sink back-pressure never feeds combinationally into   |
// |           the pop request.                                                 |
// | Ports   : clk_i  clock, rising edge                                        |
// |           rst_i  synchronous active-high reset                             |
// |           bus    fifo_burst_reader_if.master (control, FIFO, stream)       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fifo_burst_reader #(
  parameter int BITS  = 32,
  parameter int LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_burst_reader_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [LEN_W-1:0] len_q,    len_d;
  logic [LEN_W-1:0] popped_q, popped_d;
  logic [LEN_W-1:0] count_q,  count_d;
  logic [1:0]       occ_q,    occ_d;
  logic [BITS-1:0]  buf0_q,   buf0_d;   // oldest entry, drives m_data_o
  logic [BITS-1:0]  buf1_q,   buf1_d;

  logic             pop;
  logic             accept;
  logic [1:0]       occ_after_acc;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    popped_d = popped_q;
    count_d  = count_q;
    occ_d    = occ_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;

    // Pop only depends on registered occupancy, never on m_ready_i.
    // Gated by reset so a burst being aborted does not steal a FIFO word.
    pop    = !rst_i && (state_q == S_RUN) && bus.fifo_pnding_i &&
             (popped_q < len_q) && (occ_q < 2'd2);
    accept = (occ_q != 2'd0) && bus.m_ready_i;

    // Accept shifts the queue first; a popped word then lands in the first
    // free slot behind whatever remains.
    if (accept) begin
      buf0_d = buf1_q;
    end
    occ_after_acc = occ_q - {1'b0, accept};
    if (pop) begin
      if (occ_after_acc == 2'd0) begin
        buf0_d = bus.fifo_data_i;
      end else begin
        buf1_d = bus.fifo_data_i;
      end
      popped_d = popped_q + LEN_W'(1);
    end
    occ_d = occ_after_acc + {1'b0, pop};

    if (accept && (count_q != len_q)) begin
      count_d = count_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          len_d    = bus.len_i;
          popped_d = '0;
          count_d  = '0;
          state_d  = (bus.len_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (popped_q == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_q == 2'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      popped_q <= '0;
      count_q  <= '0;
      occ_q    <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      popped_q <= popped_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
    end
  end

  assign bus.fifo_pop_o = pop;
  assign bus.m_valid_o  = (occ_q != 2'd0);
  assign bus.m_data_o   = buf0_q;
  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.count_o    = count_q;

endmodule
`default_nettype wire
